fpu_pipe: RTL and testbench
===========================

// Module: fpu_pipe
// PURPOSE
//  Pipelined, parametrised successor to the combinational FPU: FADD/FMUL in fp32 and fp16 behind a valid/ready handshake.
//  Accepts one operation per cycle, carries a caller tag (destination register index) through LATENCY register stages.
//  Returns result, tag and NZCV flags to the multicycle datapath writeback.
//  Arithmetic comes from the existing fp_adder_32, fp_mul_32, fp_adder16 and fp_mul_16 units, evaluated at stage 0.
// PARAMETERS
//  LATENCY  3  register stages from accept to out_valid; legal 1..8
//  TAG_W    4  width of in_tag/out_tag
// PORTS
//  clk        input   1      rising-edge clock
//  reset      input   1      asynchronous, active-low reset
//  in_valid   input   1      operation offered
//  in_ready   output  1      block can accept this cycle
//  in_a       input   32     operand A (fp16 ops use [15:0])
//  in_b       input   32     operand B (fp16 ops use [15:0])
//  in_sel     input   2      00 fadd32, 01 fmul32, 10 fadd16, 11 fmul16 (Instr[22:21])
//  in_tag     input   TAG_W  opaque tag, returned unchanged
//  out_valid  output  1      result available
//  out_ready  input   1      consumer takes result this cycle
//  out_result output  32     result; fp16 results zero-extended to 32 bits
//  out_tag    output  TAG_W  tag of out_result
//  out_flags  output  4      {N,Z,C,V}
//  busy       output  1      any stage holds a valid op
// BEHAVIOUR
//  - Reset (reset==0, async): all stage valid bits, out_valid, out_result, out_tag, out_flags clear to 0. in_ready reads 1 on the first cycle after release.
//  - advance = !out_valid || out_ready. in_ready = advance (combinational; no dependency on in_valid).
//  - Accept: in_valid && in_ready at a rising edge. Stage 0 captures the selected unit result, computed flags, tag and valid=1.
//  - advance=1: every stage k shifts into k+1 (valid bit included), and stage 0 captures (in_valid && in_ready).
//  - advance=0: all stages hold, including bubbles (global stall; bubbles do not collapse).
//  - Last stage drives out_*. Without a stall, out_valid rises exactly LATENCY cycles after the accept edge.
//  - Throughput is 1 op/cycle while out_ready=1. Ops retire in order, and out_result/out_tag/out_flags stay stable while out_valid && !out_ready.
//  - Result select: fp16 ops read a[15:0]/b[15:0]; result = {16'b0, r16}.
//  - N = sel[1] ? result[15] : result[31]; Z = (result == 32'h0); C = 0; V per CONFIGURATION.
//  - busy = OR of all stage valid bits.
//  - A handshake with both ends active in the same cycle (out_valid && out_ready with in_valid): the retire and the accept both complete, with no bubble.
//  - When out_valid=0, the out_* data outputs hold their last value. Consumers ignore them.
//  - Reset asserted mid-operation: in-flight ops are discarded with no partial output, and no op is replayed after release.
//  - LATENCY=1: stage 0 is the output stage.
// CONFIGURATION
//  FPU_SPECIAL_FLAGS_EN defined:
//   V=1 when the result exponent is all ones (Inf/NaN): [30:23]==8'hFF for fp32, [14:10]==5'h1F for fp16.
//   C=1 when the result exponent is zero and the mantissa is nonzero (subnormal).
//   Both flags are computed at stage 0 and pipelined with the result.
//  Not defined: C=0 and V=0 always, matching the existing FPUFlags contract.
// TESTING
//  1. fadd32 in_a=32'h3F800000, in_b=32'h40000000, tag=5, out_ready=1 -> out_valid exactly LATENCY cycles later, out_result=32'h40400000, out_tag=5, flags=4'b0000.
//  2. fmul16 in_a=32'h00004000, in_b=32'h00004200 -> out_result=32'h00004600, N=0; then fadd32 1.0 + -1.0 (32'hBF800000) -> result 0, flags=4'b0100.
//  3. Back-to-back: 8 ops on consecutive cycles with out_ready=1 -> 8 consecutive out_valid cycles, tags 0..7 in order, in_ready never drops.
//  4. Stall: out_ready=0 for 5 cycles with the pipe full -> in_ready=0, out_* stable; on release, in-order drain with no loss and no duplicate.
//  5. Reset pulse (reset=0) with 2 ops in flight -> out_valid=0 and busy=0 immediately (async); after release, no stale result ever appears.
//  6. FPU_SPECIAL_FLAGS_EN: fadd32 32'h7F800000 + 32'h3F800000 -> result 32'h7F800000, flags=4'b0001; macro undefined -> flags=4'b0000.

Source files
------------

// File: rtl/fpu_pipe.sv
// fpu_pipe: pipelined FADD/FMUL (fp32/fp16) with tag and NZCV flags.
// Optional macro FPU_SPECIAL_FLAGS_EN: C = subnormal result, V = Inf/NaN result.
// Ports: clk, reset (async, active-low), in_valid/in_ready/in_a/in_b/in_sel/in_tag,
//        out_valid/out_ready/out_result/out_tag/out_flags, busy.
// Rounding is round-to-nearest-even; every NaN result is the canonical quiet NaN.

module fp_add #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic [EW+MW:0] a_i,
  input  logic [EW+MW:0] b_i,
  output logic [EW+MW:0] r_o
);
  localparam int W  = EW + MW + 1;
  localparam int MX = MW + 4;
  localparam logic [EW-1:0] EMAX = '1;

  logic [W-1:0]  x, y;
  logic [EW-1:0] xe, ye, xee, yee, d;
  logic [MX-1:0] xm, ym, al, m, mask;
  logic [MX:0]   s;
  logic [EW:0]   e;
  logic [MW+1:0] mr;
  logic          xnan, ynan, xinf, yinf, sub, rnd;
  int            lz, sh;

  always_comb begin
    // x always carries the larger magnitude
    if (a_i[W-2:0] < b_i[W-2:0]) begin
      x = b_i;
      y = a_i;
    end else begin
      x = a_i;
      y = b_i;
    end
    xe   = x[W-2:MW];
    ye   = y[W-2:MW];
    xnan = (xe == EMAX) && (x[MW-1:0] != '0);
    ynan = (ye == EMAX) && (y[MW-1:0] != '0);
    xinf = (xe == EMAX) && (x[MW-1:0] == '0);
    yinf = (ye == EMAX) && (y[MW-1:0] == '0);
    sub  = x[W-1] ^ y[W-1];
    xee  = (xe == '0) ? EW'(1) : xe;
    yee  = (ye == '0) ? EW'(1) : ye;
    xm   = {xe != '0, x[MW-1:0], 3'b000};
    ym   = {ye != '0, y[MW-1:0], 3'b000};
    d    = xee - yee;
    mask = (MX'(1) << d) - MX'(1);
    // align with sticky folded into the lsb
    if (int'(d) >= MX)
      al = {{(MX-1){1'b0}}, |ym};
    else
      al = (ym >> d) | {{(MX-1){1'b0}}, |(ym & mask)};
    if (sub)
      s = {1'b0, xm} - {1'b0, al};
    else
      s = {1'b0, xm} + {1'b0, al};
    e  = {1'b0, xee};
    lz = 0;
    for (int i = 0; i < MX; i++)
      if (s[i]) lz = MX - 1 - i;
    // left shift stops at the subnormal boundary
    sh = (lz < int'(e) - 1) ? lz : int'(e) - 1;
    if (s[MX]) begin
      m = {s[MX:2], s[1] | s[0]};
      e = e + (EW+1)'(1);
    end else begin
      m = s[MX-1:0] << sh;
      e = e - (EW+1)'(sh);
    end
    rnd = m[2] & (m[3] | m[1] | m[0]);
    mr  = {1'b0, m[MX-1:3]} + (MW+2)'(rnd);
    if (mr[MW+1]) begin
      mr = mr >> 1;
      e  = e + (EW+1)'(1);
    end
    if (s == '0)
      r_o = {x[W-1] & y[W-1], {(W-1){1'b0}}};
    else if (e >= {1'b0, EMAX})
      r_o = {x[W-1], EMAX, {MW{1'b0}}};
    else
      r_o = {x[W-1], mr[MW] ? e[EW-1:0] : {EW{1'b0}}, mr[MW-1:0]};
    if (xnan || ynan || (xinf && yinf && sub))
      r_o = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};
    else if (xinf)
      r_o = x;
  end
endmodule

module fp_mul #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic [EW+MW:0] a_i,
  input  logic [EW+MW:0] b_i,
  output logic [EW+MW:0] r_o
);
  localparam int W    = EW + MW + 1;
  localparam int MX   = MW + 4;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam logic [EW-1:0] EMAX = '1;

  logic [EW-1:0]   ae, be, aee, bee;
  logic [MW:0]     am, bm;
  logic [2*MW+1:0] p, pn;
  logic [MX-1:0]   m, mask;
  logic [MW+1:0]   mr;
  logic            an, bn, ai, bi, az, bz, sx, rnd;
  int              lz, ei, rsh;

  always_comb begin
    ae  = a_i[W-2:MW];
    be  = b_i[W-2:MW];
    an  = (ae == EMAX) && (a_i[MW-1:0] != '0);
    bn  = (be == EMAX) && (b_i[MW-1:0] != '0);
    ai  = (ae == EMAX) && (a_i[MW-1:0] == '0);
    bi  = (be == EMAX) && (b_i[MW-1:0] == '0);
    az  = (ae == '0) && (a_i[MW-1:0] == '0);
    bz  = (be == '0) && (b_i[MW-1:0] == '0);
    sx  = a_i[W-1] ^ b_i[W-1];
    aee = (ae == '0) ? EW'(1) : ae;
    bee = (be == '0) ? EW'(1) : be;
    am  = {ae != '0, a_i[MW-1:0]};
    bm  = {be != '0, b_i[MW-1:0]};
    p   = (2*MW+2)'(am) * (2*MW+2)'(bm);
    lz  = 0;
    for (int i = 0; i < 2*MW+2; i++)
      if (p[i]) lz = 2*MW + 1 - i;
    pn  = p << lz;
    // exponent of the value whose hidden bit sits at pn msb
    ei  = int'(aee) + int'(bee) - BIAS + 1 - lz;
    m   = {pn[2*MW+1:MW-1], |pn[MW-2:0]};
    rsh = 0;
    if (ei < 1) begin
      rsh = 1 - ei;
      ei  = 1;
    end
    mask = (MX'(1) << rsh) - MX'(1);
    if (rsh >= MX)
      m = {{(MX-1){1'b0}}, |m};
    else if (rsh > 0)
      m = (m >> rsh) | {{(MX-1){1'b0}}, |(m & mask)};
    rnd = m[2] & (m[3] | m[1] | m[0]);
    mr  = {1'b0, m[MX-1:3]} + (MW+2)'(rnd);
    if (mr[MW+1]) begin
      mr = mr >> 1;
      ei = ei + 1;
    end
    if (ei >= int'(EMAX))
      r_o = {sx, EMAX, {MW{1'b0}}};
    else
      r_o = {sx, mr[MW] ? EW'(ei) : {EW{1'b0}}, mr[MW-1:0]};
    if (an || bn || (ai && bz) || (bi && az))
      r_o = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};
    else if (ai || bi)
      r_o = {sx, EMAX, {MW{1'b0}}};
    else if (az || bz)
      r_o = {sx, {(W-1){1'b0}}};
  end
endmodule

module fpu_pipe #(
  parameter int LATENCY = 3,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [1:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags,
  output logic             busy
);
  logic [31:0] add32, mul32;
  logic [15:0] add16, mul16;
  logic [31:0] res_d;
  logic [3:0]  flg_d;
  logic        n_d, z_d, c_d, v_d, advance;

  logic [LATENCY-1:0] v_q;
  logic [31:0]        r_q [LATENCY];
  logic [TAG_W-1:0]   t_q [LATENCY];
  logic [3:0]         f_q [LATENCY];

  fp_add #(.EW(8), .MW(23)) u_add32 (.a_i(in_a), .b_i(in_b), .r_o(add32));
  fp_mul #(.EW(8), .MW(23)) u_mul32 (.a_i(in_a), .b_i(in_b), .r_o(mul32));
  fp_add #(.EW(5), .MW(10)) u_add16 (.a_i(in_a[15:0]), .b_i(in_b[15:0]), .r_o(add16));
  fp_mul #(.EW(5), .MW(10)) u_mul16 (.a_i(in_a[15:0]), .b_i(in_b[15:0]), .r_o(mul16));

  always_comb begin
    res_d = '0;
    unique case (in_sel)
      2'b00: res_d = add32;
      2'b01: res_d = mul32;
      2'b10: res_d = {16'h0, add16};
      2'b11: res_d = {16'h0, mul16};
    endcase
    n_d = in_sel[1] ? res_d[15] : res_d[31];
    z_d = (res_d == 32'h0);
    c_d = 1'b0;
    v_d = 1'b0;
`ifdef FPU_SPECIAL_FLAGS_EN
    if (in_sel[1]) begin
      v_d = (res_d[14:10] == 5'h1F);
      c_d = (res_d[14:10] == 5'h00) && (res_d[9:0] != '0);
    end else begin
      v_d = (res_d[30:23] == 8'hFF);
      c_d = (res_d[30:23] == 8'h00) && (res_d[22:0] != '0);
    end
`endif
    flg_d = {n_d, z_d, c_d, v_d};
  end

  assign out_valid  = v_q[LATENCY-1];
  assign out_result = r_q[LATENCY-1];
  assign out_tag    = t_q[LATENCY-1];
  assign out_flags  = f_q[LATENCY-1];
  assign advance    = !out_valid || out_ready;
  assign in_ready   = advance;
  assign busy       = |v_q;

  // data moves only with a valid op, so idle outputs keep their last value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_q[k] <= '0;
        t_q[k] <= '0;
        f_q[k] <= '0;
      end
    end else if (advance) begin
      v_q[0] <= in_valid;
      if (in_valid) begin
        r_q[0] <= res_d;
        t_q[0] <= in_tag;
        f_q[0] <= flg_d;
      end
      for (int k = 1; k < LATENCY; k++) begin
        v_q[k] <= v_q[k-1];
        if (v_q[k-1]) begin
          r_q[k] <= r_q[k-1];
          t_q[k] <= t_q[k-1];
          f_q[k] <= f_q[k-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_fpu_pipe.sv
// tb_fpu_pipe: scoreboard bench for fpu_pipe.
// Directed vectors; a negedge monitor pops expected results on each retire.

module tb_fpu_pipe;
  localparam int LAT = 3;

`ifdef FPU_SPECIAL_FLAGS_EN
  localparam logic [3:0] F_INF = 4'b0001;
  localparam logic [3:0] F_SUB = 4'b0010;
`else
  localparam logic [3:0] F_INF = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0000;
`endif

  typedef struct {
    logic [31:0] r;
    logic [3:0]  t;
    logic [3:0]  f;
  } exp_t;

  logic        clk = 0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_a, in_b, out_result;
  logic [1:0]  in_sel;
  logic [3:0]  in_tag, out_tag, out_flags;

  exp_t sb[$];
  int   ret_cyc[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc = 0;
  int   stalls = 0;

  fpu_pipe #(.LATENCY(LAT), .TAG_W(4)) dut (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .out_flags(out_flags), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      n_vec++;
      ret_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got tag %0d res %h, expected no output",
                 out_tag, out_result);
      end else begin
        e = sb.pop_front();
        if (out_result !== e.r || out_tag !== e.t || out_flags !== e.f) begin
          n_err++;
          $display("FAIL retire: got res %h tag %0d flg %b, expected res %h tag %0d flg %b",
                   out_result, out_tag, out_flags, e.r, e.t, e.f);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic issue(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] er, input logic [3:0] ef);
    int   n;
    exp_t e;
    in_valid = 1;
    in_sel   = sel;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      stalls++;
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 (tag %0d)", tag);
    end else begin
      e.r = er;
      e.t = tag;
      e.f = ef;
      sb.push_back(e);
      acc = cyc;
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n     = 0;
    in_valid  = 0;
    in_a      = '0;
    in_b      = '0;
    in_sel    = '0;
    in_tag    = '0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag_flags", {24'd0, out_tag, out_flags}, 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1.0 + 2.0 with latency measured from the accept cycle
    issue(2'b00, 32'h3F800000, 32'h40000000, 4'd5, 32'h40400000, 4'b0000);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(cyc - acc), 32'(LAT));
    drain("drain_t1");

    issue(2'b11, 32'h00004000, 32'h00004200, 4'd1, 32'h00004600, 4'b0000);
    issue(2'b00, 32'h3F800000, 32'hBF800000, 4'd2, 32'h00000000, 4'b0100);
    issue(2'b01, 32'h40000000, 32'h40400000, 4'd3, 32'h40C00000, 4'b0000);
    issue(2'b10, 32'hFFFF3C00, 32'h00003C00, 4'd4, 32'h00004000, 4'b0000);
    issue(2'b00, 32'h3FC00000, 32'hC0200000, 4'd5, 32'hBF800000, 4'b1000);
    issue(2'b11, 32'h0000BC00, 32'h00004000, 4'd6, 32'h0000C000, 4'b1000);
    issue(2'b01, 32'h00800000, 32'h3F000000, 4'd7, 32'h00400000, F_SUB);
    issue(2'b00, 32'h7F800000, 32'h3F800000, 4'd8, 32'h7F800000, F_INF);
    issue(2'b11, 32'h00007BFF, 32'h00004000, 4'd9, 32'h00007C00, F_INF);
    drain("drain_vectors");

    // back-to-back: 8 ops, 1.0 * x in fp16
    ret_cyc.delete();
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] x;
      x = 16'h4000 + 16'(i * 16'h0100);
      issue(2'b11, 32'h00003C00, {16'h0, x}, 4'(i), {16'h0, x}, 4'b0000);
    end
    drain("drain_b2b");
    chk("b2b_in_ready_drops", 32'(stalls), 32'd0);
    chk("b2b_count", 32'(ret_cyc.size()), 32'd8);
    if (ret_cyc.size() == 8)
      chk("b2b_consecutive", 32'(ret_cyc[7] - ret_cyc[0]), 32'd7);

    // stall with the pipe full
    out_ready = 0;
    for (int i = 0; i < LAT; i++) begin
      logic [15:0] x;
      x = 16'h4400 + 16'(i * 16'h0040);
      issue(2'b11, 32'h00003C00, {16'h0, x}, 4'(10 + i), {16'h0, x}, 4'b0000);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      if (sb.size() != 0) begin
        chk("stall_out_result", out_result, sb[0].r);
        chk("stall_out_tag", 32'(out_tag), 32'(sb[0].t));
      end
    end
    @(posedge clk);
    #1 out_ready = 1;
    ret_cyc.delete();
    drain("drain_stall");
    chk("stall_drain_count", 32'(ret_cyc.size()), 32'(LAT));

    // async reset with two ops in flight
    issue(2'b00, 32'h3F800000, 32'h3F800000, 4'd14, 32'h40000000, 4'b0000);
    issue(2'b00, 32'h40000000, 32'h40000000, 4'd15, 32'h40800000, 4'b0000);
    rst_n = 0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
